// File: rtl/pattern_scan_ctrl_if.sv
// Word stream from the front end into the scan controller: valid/ready with a W-bit payload.
interface pattern_scan_ctrl_if #(
  parameter int unsigned W = 8
);
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Frame sequencer: loads words over a valid/ready stream, shifts them out MSB-first and
// matches the bit stream against a programmable pattern (overlapping matches allowed).
module pattern_scan_ctrl #(
  parameter int unsigned W    = 8,
  parameter int unsigned PLEN = 5,
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PLEN-1:0] cfg_pattern,
  input  logic [7:0]      frame_words,
  pattern_scan_ctrl_if.slave s,
  output logic            bit_valid,
  output logic            bit_out,
  output logic            match,
  output logic [CNTW-1:0] match_count,
  output logic            busy,
  output logic            done
);

  localparam int unsigned IW = $clog2(W);
  localparam int unsigned FW = $clog2(PLEN + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    word_q, word_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      left_q, left_d;
  logic [PLEN-1:0] pat_q, pat_d;
  logic [PLEN-1:0] hist_q, hist_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            match_q, match_d;
  logic [CNTW-1:0] count_q, count_d;

  logic            shift_bit;
  logic [PLEN-1:0] hist_shift;
  logic [FW-1:0]   fill_inc;

  // State register; reset discards any partial frame and clears the visible count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      word_q  <= '0;
      idx_q   <= '0;
      left_q  <= '0;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  // Next-state logic for the sequencer and the matcher.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    left_d     = left_q;
    pat_d      = pat_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    match_d    = 1'b0;
    count_d    = count_q;
    shift_bit  = word_q[idx_q];
    hist_shift = {hist_q[PLEN-2:0], shift_bit};
    fill_inc   = (fill_q == FW'(PLEN)) ? fill_q : fill_q + FW'(1);

    case (state_q)
      StIdle: begin
        if (start) begin
          count_d = '0;
          if (frame_words != 8'd0) begin
            pat_d   = cfg_pattern;
            left_d  = frame_words;
            hist_d  = '0;
            fill_d  = '0;
            state_d = StLoad;
          end else begin
            state_d = StDone;
          end
        end
      end
      StLoad: begin
        if (s.s_valid) begin
          word_d  = s.s_data;
          idx_d   = IW'(W - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        // History persists across words so matches may straddle a word boundary.
        hist_d = hist_shift;
        fill_d = fill_inc;
        if ((hist_shift == pat_q) && (fill_inc == FW'(PLEN))) begin
          match_d = 1'b1;
          if (count_q != {CNTW{1'b1}}) count_d = count_q + CNTW'(1);
        end
        if (idx_q == '0) begin
          if (left_q == 8'd1) begin
            state_d = StDone;
          end else begin
            left_d  = left_q - 8'd1;
            state_d = StLoad;
          end
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from state only; s_ready never depends on s_valid.
  always_comb begin
    s.s_ready   = (state_q == StLoad);
    bit_valid   = (state_q == StShift);
    bit_out     = (state_q == StShift) && shift_bit;
    busy        = (state_q == StLoad) || (state_q == StShift);
    done        = (state_q == StDone);
    match       = match_q;
    match_count = count_q;
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: directed vector table, hand-written reset sequences and
// random frames checked against a sliding-window reference model.
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] cfg_pattern;
  logic [7:0] frame_words;
  logic       s_valid;
  logic [7:0] s_data;

  logic       bit_valid, bit_out, match, busy, done;
  logic [7:0] match_count;
  logic       bit_valid2, bit_out2, match2, busy2, done2;
  logic [1:0] match_count2;

  int checks = 0;
  int errors = 0;

  pattern_scan_ctrl_if #(.W(8)) sif ();
  pattern_scan_ctrl_if #(.W(8)) sif2 ();

  assign sif.s_valid  = s_valid;
  assign sif.s_data   = s_data;
  assign sif2.s_valid = s_valid;
  assign sif2.s_data  = s_data;

  pattern_scan_ctrl #(.W(8), .PLEN(5), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_pattern(cfg_pattern),
    .frame_words(frame_words), .s(sif.slave), .bit_valid(bit_valid), .bit_out(bit_out),
    .match(match), .match_count(match_count), .busy(busy), .done(done)
  );

  // Narrow-counter copy for saturation; shares all stimulus with dut.
  pattern_scan_ctrl #(.W(8), .PLEN(5), .CNTW(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .cfg_pattern(cfg_pattern),
    .frame_words(frame_words), .s(sif2.slave), .bit_valid(bit_valid2), .bit_out(bit_out2),
    .match(match2), .match_count(match_count2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       pat;
    logic [7:0]       nw;
    logic [2:0][7:0]  w;
    logic [7:0]       stall0;
    logic             mid;
    logic [31:0]      exp_mask;
    logic [7:0]       exp_cnt;
    logic [7:0]       exp_cnt2;
    logic [7:0]       exp_dcyc;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: list the frame bits MSB-first and slide a PLEN window over them.
  task automatic model(input logic [4:0] pat, input int nw, input logic [7:0] words [16],
                       output logic [127:0] bits, output int nbits,
                       output logic [127:0] mask, output int cnt);
    int b[$];
    bit hit;
    bits = '0; mask = '0; cnt = 0;
    for (int w = 0; w < nw; w++)
      for (int i = 7; i >= 0; i--) b.push_back(int'(words[w][i]));
    nbits = b.size();
    foreach (b[k]) bits = {bits[126:0], b[k][0]};
    for (int k = 4; k < b.size(); k++) begin
      hit = 1'b1;
      for (int j = 0; j < 5; j++) if (b[k-4+j] != int'(pat[4-j])) hit = 1'b0;
      if (hit) begin
        mask[k] = 1'b1;
        cnt++;
      end
    end
  endtask

  // Drive one frame and observe it; mid=1 also pokes start mid-frame and in DONE.
  task automatic run_frame(input logic [4:0] pat, input int nw, input logic [7:0] words [16],
                           input int stall0, input bit rnd, input bit mid,
                           output logic [127:0] bits, output int nbits,
                           output logic [127:0] mask, output int cnt, output int cnt2,
                           output int dcyc, output bit proto, output int stalls,
                           output int pre);
    int cyc, widx, stall_left;
    bit got_done;
    bits = '0; nbits = 0; mask = '0; cnt = -1; cnt2 = -1; dcyc = -1;
    proto = 1'b1; stalls = 0; widx = 0; got_done = 1'b0; stall_left = stall0; cyc = 0;
    @(negedge clk);
    pre = int'(match_count);
    start = 1'b1; cfg_pattern = pat; frame_words = 8'(nw); s_valid = 1'b0;
    while (!got_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        cfg_pattern = ~pat;
        frame_words = 8'($urandom_range(1, 255));
        if (match_count != 8'd0) proto = 1'b0;
      end
      if (match) begin
        if (nbits > 0) mask[nbits-1] = 1'b1;
        else proto = 1'b0;
      end
      if (done) begin
        got_done = 1'b1;
        dcyc = cyc;
        cnt = int'(match_count);
        cnt2 = int'(match_count2);
        if (busy || sif.s_ready || bit_valid) proto = 1'b0;
        start = mid;
        cfg_pattern = pat;
        frame_words = 8'd1;
      end else begin
        if (!busy || (sif.s_ready == bit_valid)) proto = 1'b0;
        if (bit_valid) begin
          bits = {bits[126:0], bit_out};
          nbits++;
        end
        start = mid && (cyc == 5);
        if (sif.s_ready) begin
          if (stall_left > 0) begin
            s_valid = 1'b0;
            stall_left--;
            stalls++;
          end else begin
            s_valid = 1'b1;
            s_data = words[widx % 16];
            widx++;
            stall_left = rnd ? int'($urandom_range(0, 2)) : 0;
          end
        end else begin
          s_valid = 1'($urandom_range(0, 1));
          s_data = 8'($urandom);
        end
      end
    end
    if (!got_done) proto = 1'b0;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b0;
    if (busy || done) proto = 1'b0;
  endtask

  logic [7:0]   words [16];
  logic [127:0] obits, mbits, omask, mmask;
  int           onb, mnb, ocnt, ocnt2, mcnt, odcyc, ostalls, opre, prev_cnt;
  bit           oproto;
  string        tag;

  initial begin
    vecs[0] = '{pat: 5'b11010, nw: 8'd1, w: {8'h00, 8'h00, 8'hDA}, stall0: 8'd0, mid: 1'b0,
                exp_mask: 32'h80, exp_cnt: 8'd1, exp_cnt2: 8'd1, exp_dcyc: 8'd10};
    vecs[1] = '{pat: 5'b11010, nw: 8'd2, w: {8'h00, 8'h40, 8'h1B}, stall0: 8'd0, mid: 1'b0,
                exp_mask: 32'h400, exp_cnt: 8'd1, exp_cnt2: 8'd1, exp_dcyc: 8'd19};
    vecs[2] = '{pat: 5'b10101, nw: 8'd1, w: {8'h00, 8'h00, 8'hAA}, stall0: 8'd0, mid: 1'b0,
                exp_mask: 32'h50, exp_cnt: 8'd2, exp_cnt2: 8'd2, exp_dcyc: 8'd10};
    vecs[3] = '{pat: 5'b10101, nw: 8'd1, w: {8'h00, 8'h00, 8'h00}, stall0: 8'd0, mid: 1'b0,
                exp_mask: 32'h0, exp_cnt: 8'd0, exp_cnt2: 8'd0, exp_dcyc: 8'd10};
    vecs[4] = '{pat: 5'b11010, nw: 8'd1, w: {8'h00, 8'h00, 8'hDA}, stall0: 8'd3, mid: 1'b0,
                exp_mask: 32'h80, exp_cnt: 8'd1, exp_cnt2: 8'd1, exp_dcyc: 8'd13};
    vecs[5] = '{pat: 5'b10101, nw: 8'd0, w: {8'h00, 8'h00, 8'h00}, stall0: 8'd0, mid: 1'b0,
                exp_mask: 32'h0, exp_cnt: 8'd0, exp_cnt2: 8'd0, exp_dcyc: 8'd1};
    vecs[6] = '{pat: 5'b10101, nw: 8'd2, w: {8'h00, 8'hAA, 8'hAA}, stall0: 8'd0, mid: 1'b1,
                exp_mask: 32'h5550, exp_cnt: 8'd6, exp_cnt2: 8'd3, exp_dcyc: 8'd19};
    vecs[7] = '{pat: 5'b10101, nw: 8'd3, w: {8'hAA, 8'hAA, 8'hAA}, stall0: 8'd0, mid: 1'b0,
                exp_mask: 32'h555550, exp_cnt: 8'd10, exp_cnt2: 8'd3, exp_dcyc: 8'd28};

    reset = 1'b1; start = 1'b0; cfg_pattern = '0; frame_words = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset outputs",
          {sif.s_ready, bit_valid, bit_out, match, busy, done, match_count},
          16'h0);
    check("reset outputs sat",
          {sif2.s_ready, bit_valid2, bit_out2, match2, busy2, done2, match_count2},
          10'h0);
    prev_cnt = 0;

    // Directed vectors.
    foreach (vecs[i]) begin
      for (int k = 0; k < 16; k++) words[k] = (k < 3) ? vecs[i].w[k] : 8'h00;
      run_frame(vecs[i].pat, int'(vecs[i].nw), words, int'(vecs[i].stall0), 1'b0,
                vecs[i].mid, obits, onb, omask, ocnt, ocnt2, odcyc, oproto, ostalls, opre);
      model(vecs[i].pat, int'(vecs[i].nw), words, mbits, mnb, mmask, mcnt);
      tag = $sformatf("vec%0d", i);
      check({tag, " count held"}, 128'(opre), 128'(prev_cnt));
      check({tag, " bits"}, obits, mbits);
      check({tag, " nbits"}, 128'(onb), 128'(mnb));
      check({tag, " match mask"}, omask, 128'(vecs[i].exp_mask));
      check({tag, " count"}, 128'(ocnt), 128'(vecs[i].exp_cnt));
      check({tag, " sat count"}, 128'(ocnt2), 128'(vecs[i].exp_cnt2));
      check({tag, " done cycle"}, 128'(odcyc), 128'(vecs[i].exp_dcyc));
      check({tag, " protocol"}, 128'(oproto), 128'(1));
      prev_cnt = int'(vecs[i].exp_cnt);
    end

    // Reset in the middle of SHIFT: two matches already counted, then everything clears.
    @(negedge clk);
    start = 1'b1; cfg_pattern = 5'b10101; frame_words = 8'd2; s_valid = 1'b1; s_data = 8'hAA;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre-reset count", 128'(match_count), 128'(2));
    check("pre-reset busy", 128'({busy, bit_valid}), 128'(2'b11));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    s_valid = 1'b0;
    check("mid reset outputs",
          {sif.s_ready, bit_valid, bit_out, match, busy, done, match_count},
          16'h0);
    @(negedge clk);
    check("mid reset idle", 128'({busy, done, match_count}), 128'(0));
    prev_cnt = 0;
    for (int k = 0; k < 16; k++) words[k] = (k < 3) ? vecs[0].w[k] : 8'h00;
    run_frame(vecs[0].pat, 1, words, 0, 1'b0, 1'b0,
              obits, onb, omask, ocnt, ocnt2, odcyc, oproto, ostalls, opre);
    check("post reset mask", omask, 128'(vecs[0].exp_mask));
    check("post reset count", 128'(ocnt), 128'(vecs[0].exp_cnt));
    check("post reset done cycle", 128'(odcyc), 128'(vecs[0].exp_dcyc));
    prev_cnt = ocnt;

    // Random frames against the reference model.
    for (int r = 0; r < 30; r++) begin
      logic [4:0] pat;
      int nw;
      pat = 5'($urandom);
      nw = int'($urandom_range(0, 6));
      for (int k = 0; k < 16; k++) begin
        case ($urandom_range(0, 3))
          0: words[k] = 8'hAA;
          1: words[k] = 8'h55;
          2: words[k] = {pat, pat[4:2]};
          default: words[k] = 8'($urandom);
        endcase
      end
      run_frame(pat, nw, words, int'($urandom_range(0, 2)), 1'b1, r[0],
                obits, onb, omask, ocnt, ocnt2, odcyc, oproto, ostalls, opre);
      model(pat, nw, words, mbits, mnb, mmask, mcnt);
      tag = $sformatf("rand%0d", r);
      check({tag, " count held"}, 128'(opre), 128'(prev_cnt));
      check({tag, " bits"}, obits, mbits);
      check({tag, " nbits"}, 128'(onb), 128'(mnb));
      check({tag, " match mask"}, omask, mmask);
      check({tag, " count"}, 128'(ocnt), 128'(mcnt));
      check({tag, " sat count"}, 128'(ocnt2), 128'((mcnt > 3) ? 3 : mcnt));
      check({tag, " done cycle"}, 128'(odcyc), 128'(nw * 9 + 1 + ostalls));
      check({tag, " protocol"}, 128'(oproto), 128'(1));
      prev_cnt = mcnt;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Sequencer and programmable matcher for the serial pattern-detection path. Accepts a frame of parallel words over a valid/ready handshake and serializes each word MSB-first, one bit per cycle. Checks the bit stream against a runtime-programmed pattern, with overlapping matches allowed. Reports a per-bit match strobe and a frame match count at end of frame. Sits between the word-oriented front end and the software-visible status registers.

## Interface
- W, 8, input word width (>=2)
- PLEN, 5, pattern length in bits (2..W)
- CNTW, 8, match counter width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  frame start request, sampled only in IDLE
- cfg_pattern  in  PLEN  pattern; bit PLEN-1 is matched first; latched on accepted start
- frame_words  in  8  words in frame; latched on accepted start
- s_valid  in  1  input word valid
- s_data  in  W  input word
- s_ready  out  1  word accept; high only in LOAD
- bit_valid  out  1  high in every SHIFT cycle
- bit_out  out  1  current serial bit, s_data[bit_idx] of captured word
- match  out  1  registered; one-cycle strobe per detected match
- match_count  out  CNTW  matches in current/last frame; saturating
- busy  out  1  high in LOAD and SHIFT
- done  out  1  one-cycle end-of-frame strobe

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- Reset (any state, mid-frame included) forces IDLE. All outputs read 0 in the cycle after reset, including match_count. History, fill counter and word counter are cleared. A partial frame is discarded.
- IDLE:
  - start=1 with frame_words!=0: latch cfg_pattern and frame_words, clear history, fill and match_count, go LOAD.
  - start=1 with frame_words==0: go DONE with match_count=0.
  - start=0: stay in IDLE.
- LOAD: s_ready=1. On s_valid&s_ready, capture s_data, set bit_idx=W-1 and go SHIFT. Otherwise hold with no bit_valid.
- SHIFT: each cycle emits bit_out=word[bit_idx] with bit_valid=1, and updates history <= {history[PLEN-2:0], bit_out}. fill increments, saturating at PLEN.
  - At bit_idx==0: if words_left==1 go DONE; else decrement words_left and go LOAD.
- Match rule: in the SHIFT cycle where the updated history equals the latched pattern and updated fill==PLEN, register match=1 and match_count+1 (held at 2^CNTW-1 on saturation). Both are visible the next cycle.
- Matches span word boundaries: history is kept across words within a frame and cleared only at start.
- DONE: done=1 for exactly one cycle, then IDLE. match_count holds its final value until the next accepted start.
- start while busy or in DONE is ignored. cfg_pattern and frame_words changes after start have no effect on the running frame.

## Timing
- A word costs 1 LOAD cycle (plus any s_valid stall) and W SHIFT cycles.
- With s_valid held high and start accepted at edge 0: LOAD is cycle 1 and SHIFT is cycles 2..W+1 for word 0. DONE is cycle F*(W+1)+1 for F words.
- match lags its bit by 1 cycle. A match on the final bit appears together with done, and match_count already includes it in the done cycle.
- Zero-word frame: done is asserted in the cycle after start.
- s_ready is combinational from state only; it has no dependency on s_valid.

## Test plan
- Single word: PLEN=5, pattern 11010, frame_words=1, s_data=0xDA (11011010). Expect 8 bit_valid cycles with bits 1,1,0,1,1,0,1,0. Expect one match, the cycle after the 8th bit, coincident with done. match_count=1.
- Cross-word match: pattern 11010, frame_words=2, words 0x1B, 0x40. Expect a single match the cycle after the 3rd bit of word 1. match_count=1 at done.
- Overlapping matches: pattern 10101, word 0xAA. Expect matches after bits 5 and 7, match_count=2. Then start a second frame with 0x00 and expect match_count reset to 0 at start and 0 at done.
- Backpressure: hold s_valid=0 for 3 cycles in LOAD. Expect s_ready=1, bit_valid=0 and busy=1 throughout. The word is accepted on the first s_valid cycle and shifting starts the next cycle.
- Boundaries: frame_words=0 gives done one cycle after start with match_count=0. A start pulse mid-frame is ignored. reset asserted in SHIFT gives the next cycle all outputs 0 and state IDLE, and a new frame after that runs normally.
- Saturation (CNTW=2): pattern 10101 with words 0xAA, 0xAA, 0xAA. match_count stops at 3 while match strobes continue.
